hazard_fwd_unit: RTL and testbench
==================================

// Module: hazard_fwd_unit
// PURPOSE
//  Parametrised hazard-detection and operand-forwarding unit for the pipelined RV32IM core.
//  Keeps a scoreboard shift register of in-flight writers (EX..WB) and forwards the youngest
//  ready result to the ID-stage operands. Stalls ID on not-yet-ready producers (load-use).
//  Honours branch flush and external hold. Sits beside ID; feeds the ID/EX operand muxes.
// PARAMETERS
//  XLEN        32  operand/result width
//  RA_W        5   register address width
//  NUM_STAGES  3   tracked stages after ID (0=EX,1=MEM,...,NUM_STAGES-1=WB); >=2
//  LOAD_STAGE  1   first stage index whose stage_data holds valid load data; <NUM_STAGES
// PORTS
//  CLK          in   1              clock, rising edge
//  RST          in   1              asynchronous active-low reset (0 = reset)
//  id_valid     in   1              ID holds a valid instruction
//  id_rs1       in   RA_W           source reg 1 address
//  id_rs2       in   RA_W           source reg 2 address
//  id_rs1_used  in   1              instruction reads rs1
//  id_rs2_used  in   1              instruction reads rs2
//  id_rd        in   RA_W           destination reg
//  id_we        in   1              instruction writes rd
//  id_is_load   in   1              instruction is a load
//  rf_rs1_data  in   XLEN           register-file read data rs1
//  rf_rs2_data  in   XLEN           register-file read data rs2
//  stage_data   in   NUM_STAGES*XLEN result at output of stage i, slice [i*XLEN +: XLEN]
//  hold         in   1              external freeze (mul/div busy, memory wait)
//  flush        in   1              branch/jump taken in EX: squash the ID instruction
//  stall        out  1              ID/IF must hold; bubble injected into EX
//  fwd_rs1_hit  out  1              rs1 value taken from a stage, not the RF
//  fwd_rs2_hit  out  1              rs2 value taken from a stage, not the RF
//  fwd_rs1_data out  XLEN           resolved rs1 operand
//  fwd_rs2_data out  XLEN           resolved rs2 operand
// BEHAVIOUR
//  - Scoreboard entry per stage: {valid, rd, we, is_load}. Reset: all entries invalid,
//    flush_pend=0; outputs then: stall=0, hits=0, fwd data = RF data (combinational).
//  - Match(i,rs): entry valid & we & rd==rs & rs!=0. x0 never forwarded, never stalls.
//  - Per operand: select youngest (lowest i) match. Ready(i) = !is_load | i>=LOAD_STAGE.
//    Youngest match ready -> hit=1, data=stage_data[i]. No match -> hit=0, data=RF.
//    Youngest match not ready -> operand hazard (older ready matches are ignored).
//  - stall = id_valid & ((rs1_used & hazard1) | (rs2_used & hazard2)); combinational, 0 lat.
//  - Update on CLK rise, when hold=0: entry[i]<=entry[i-1] for i>=1; entry[NUM_STAGES-1]
//    retires. entry[0] <= ID fields if id_valid & !stall & !(flush|flush_pend), else bubble.
//  - hold=1: all entries frozen; stall output still computed; flush sampled into flush_pend.
//  - flush_pend cleared on first hold=0 edge (where it squashes the issue); flush wins over
//    stall (squashed instruction never issues, bubble injected).
//  - Load-use with defaults: exactly 1 stall cycle, then forward from MEM (stage 1).
//  - RST low mid-operation: entries and flush_pend clear immediately (async).
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs perf_stall_cnt[31:0], perf_fwd_cnt[31:0]; stall_cnt
//    +1 each hold=0 cycle with stall=1; fwd_cnt +1 each issuing cycle with any hit; both
//    wrap at 2^32, reset to 0. Not defined: ports and counters absent, logic otherwise same.
// TESTING
//  1. EX: add x5 (stage_data[0]=0x11); ID rs1=x5 -> fwd_rs1_hit=1, fwd_rs1_data=0x11, stall=0.
//  2. EX: lw x6; ID rs2=x6 -> stall=1 one cycle, EX bubble; next: MEM data 0xAB forwarded, stall=0.
//  3. EX: writer rd=x0; ID rs1=x0, rf=0 -> hit=0, data=0, stall=0.
//  4. EX writes x7=0x2, MEM writes x7=0x1; ID rs1=x7 -> fwd_rs1_data=0x2 (youngest).
//  5. hold=1 + flush=1 for 3 cycles -> entries frozen; first hold=0 edge: entry[0] bubble.
//  6. Load-use stall active, drive RST=0 -> stall=0 and all entries invalid before next edge.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: scoreboard-based hazard detection and operand forwarding
// for the ID stage of the pipelined RV32IM core.
// Tracks in-flight writers in stages EX..WB, forwards the youngest ready
// result to each ID operand, and stalls ID on a not-yet-ready producer.
// Optional: define HAZARD_PERF_EN to add the perf_stall_cnt / perf_fwd_cnt
// counter outputs.
module hazard_fwd_unit #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_STAGE = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       id_valid,
  input  logic [RA_W-1:0]            id_rs1,
  input  logic [RA_W-1:0]            id_rs2,
  input  logic                       id_rs1_used,
  input  logic                       id_rs2_used,
  input  logic [RA_W-1:0]            id_rd,
  input  logic                       id_we,
  input  logic                       id_is_load,
  input  logic [XLEN-1:0]            rf_rs1_data,
  input  logic [XLEN-1:0]            rf_rs2_data,
  input  logic [NUM_STAGES*XLEN-1:0] stage_data,
  input  logic                       hold,
  input  logic                       flush,
  output logic                       stall,
  output logic                       fwd_rs1_hit,
  output logic                       fwd_rs2_hit,
  output logic [XLEN-1:0]            fwd_rs1_data,
  output logic [XLEN-1:0]            fwd_rs2_data
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_fwd_cnt
`endif
);

  localparam int unsigned NS = NUM_STAGES;
  localparam int unsigned LS = LOAD_STAGE;

  // Scoreboard, index 0 = EX (youngest) .. NS-1 = WB (oldest)
  logic [NS-1:0] sb_valid;
  logic [NS-1:0] sb_we;
  logic [NS-1:0] sb_load;
  logic [RA_W-1:0] sb_rd [NS];
  logic          flush_pend;

  logic hazard1;
  logic hazard2;
  logic issue;

  // Operand resolution: scan oldest to youngest so the youngest match wins
  always_comb begin
    fwd_rs1_hit  = 1'b0;
    fwd_rs2_hit  = 1'b0;
    hazard1      = 1'b0;
    hazard2      = 1'b0;
    fwd_rs1_data = rf_rs1_data;
    fwd_rs2_data = rf_rs2_data;
    for (int unsigned k = 0; k < NS; k++) begin
      int unsigned i;
      logic        rdy;
      i   = NS - 1 - k;
      rdy = !sb_load[i] || (i >= LS);
      if (sb_valid[i] && sb_we[i] && (sb_rd[i] == id_rs1) && (id_rs1 != '0)) begin
        fwd_rs1_hit  = rdy;
        hazard1      = !rdy;
        fwd_rs1_data = rdy ? stage_data[i*XLEN +: XLEN] : rf_rs1_data;
      end
      if (sb_valid[i] && sb_we[i] && (sb_rd[i] == id_rs2) && (id_rs2 != '0)) begin
        fwd_rs2_hit  = rdy;
        hazard2      = !rdy;
        fwd_rs2_data = rdy ? stage_data[i*XLEN +: XLEN] : rf_rs2_data;
      end
    end
  end

  // Stall and issue decision; a pending or live flush squashes the ID instruction
  always_comb begin
    stall = id_valid && ((id_rs1_used && hazard1) || (id_rs2_used && hazard2));
    issue = id_valid && !stall && !(flush || flush_pend);
  end

  // Scoreboard shift; hold freezes entries but still records a flush
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sb_valid   <= '0;
      sb_we      <= '0;
      sb_load    <= '0;
      flush_pend <= 1'b0;
      for (int unsigned i = 0; i < NS; i++) sb_rd[i] <= '0;
    end else if (hold) begin
      flush_pend <= flush_pend | flush;
    end else begin
      flush_pend <= 1'b0;
      sb_valid   <= {sb_valid[NS-2:0], issue};
      sb_we      <= {sb_we[NS-2:0],   issue & id_we};
      sb_load    <= {sb_load[NS-2:0], issue & id_is_load};
      for (int unsigned i = 1; i < NS; i++) sb_rd[i] <= sb_rd[i-1];
      sb_rd[0]   <= issue ? id_rd : '0;
    end
  end

`ifdef HAZARD_PERF_EN
  // Performance counters, free-running with natural 32-bit wrap
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else if (!hold) begin
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (issue && (fwd_rs1_hit || fwd_rs2_hit)) perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed self-checking bench for hazard_fwd_unit (default parameters).
module tb_hazard_fwd_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic [95:0] stage_data;
  logic        hold, flush;
  logic        stall, fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_fwd_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  hazard_fwd_unit #(.XLEN(32), .RA_W(5), .NUM_STAGES(3), .LOAD_STAGE(1)) dut (
    .CLK(CLK), .RST(RST),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .stage_data(stage_data), .hold(hold), .flush(flush),
    .stall(stall), .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_we = 0; id_is_load = 0;
  endtask

  // Put one writer into ID; it issues at the next tick
  task automatic writer(input logic [4:0] rd, input logic ld);
    idle();
    id_valid = 1; id_rd = rd; id_we = 1; id_is_load = ld;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    idle(); hold = 0; flush = 0;
    rf_rs1_data = 32'h1111_0001; rf_rs2_data = 32'h2222_0002;
    stage_data = {32'h3, 32'h2, 32'h1};
    RST = 0;
    id_valid = 1; id_rs1 = 5'd3; id_rs2 = 5'd4; id_rs1_used = 1; id_rs2_used = 1;
    #2;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if ({fwd_rs1_hit, fwd_rs2_hit} !== 2'b00) begin failures++; $display("FAIL reset_hits got=%b exp=00", {fwd_rs1_hit, fwd_rs2_hit}); end
    checks++; if (fwd_rs1_data !== 32'h1111_0001) begin failures++; $display("FAIL reset_rs1_data got=%h exp=11110001", fwd_rs1_data); end
    checks++; if (fwd_rs2_data !== 32'h2222_0002) begin failures++; $display("FAIL reset_rs2_data got=%h exp=22220002", fwd_rs2_data); end
    @(negedge CLK); RST = 1;
    idle(); tick();
  endtask

  task automatic test_fwd_ex();
    writer(5'd5, 0); tick();
    idle(); id_valid = 1; id_rs1 = 5'd5; id_rs1_used = 1; id_rs2 = 5'd6; id_rs2_used = 1;
    stage_data = {32'hC, 32'hB, 32'h11}; rf_rs1_data = 32'hDEAD; rf_rs2_data = 32'hBEEF;
    #1;
    checks++; if (fwd_rs1_hit !== 1'b1) begin failures++; $display("FAIL ex_rs1_hit got=%b exp=1", fwd_rs1_hit); end
    checks++; if (fwd_rs1_data !== 32'h11) begin failures++; $display("FAIL ex_rs1_data got=%h exp=11", fwd_rs1_data); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ex_stall got=%b exp=0", stall); end
    checks++; if (fwd_rs2_hit !== 1'b0 || fwd_rs2_data !== 32'hBEEF) begin failures++; $display("FAIL ex_rs2_nomatch got=%b/%h exp=0/0000beef", fwd_rs2_hit, fwd_rs2_data); end
    drain();
  endtask

  task automatic test_load_use();
    writer(5'd6, 1); tick();
    idle(); id_valid = 1; id_rs2 = 5'd6; id_rs2_used = 1; id_rd = 5'd9; id_we = 1;
    stage_data = {32'h0, 32'hAB, 32'hFF}; rf_rs2_data = 32'h5555;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
    checks++; if (fwd_rs2_hit !== 1'b0 || fwd_rs2_data !== 32'h5555) begin failures++; $display("FAIL lu_rs2_while_stall got=%b/%h exp=0/00005555", fwd_rs2_hit, fwd_rs2_data); end
    tick();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall_after got=%b exp=0", stall); end
    checks++; if (fwd_rs2_hit !== 1'b1 || fwd_rs2_data !== 32'hAB) begin failures++; $display("FAIL lu_mem_fwd got=%b/%h exp=1/000000ab", fwd_rs2_hit, fwd_rs2_data); end
    // the stalled rd=9 must not have entered EX
    id_rs1 = 5'd9; id_rs1_used = 1; rf_rs1_data = 32'h7777; #1;
    checks++; if (fwd_rs1_hit !== 1'b0 || fwd_rs1_data !== 32'h7777) begin failures++; $display("FAIL lu_bubble got=%b/%h exp=0/00007777", fwd_rs1_hit, fwd_rs1_data); end
    drain();
  endtask

  task automatic test_x0();
    writer(5'd0, 0); tick();
    idle(); id_valid = 1; id_rs1 = 5'd0; id_rs1_used = 1;
    rf_rs1_data = 32'h0; stage_data = {32'h0, 32'h0, 32'h55};
    #1;
    checks++; if (fwd_rs1_hit !== 1'b0 || fwd_rs1_data !== 32'h0 || stall !== 1'b0) begin failures++; $display("FAIL x0_writer got=%b/%h/%b exp=0/00000000/0", fwd_rs1_hit, fwd_rs1_data, stall); end
    drain();
    writer(5'd0, 1); tick();
    idle(); id_valid = 1; id_rs1 = 5'd0; id_rs1_used = 1; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL x0_load_stall got=%b exp=0", stall); end
    drain();
  endtask

  task automatic test_youngest();
    writer(5'd7, 0); tick();
    writer(5'd7, 0); tick();
    idle(); id_valid = 1; id_rs1 = 5'd7; id_rs1_used = 1;
    stage_data = {32'h0, 32'h1, 32'h2}; #1;
    checks++; if (fwd_rs1_hit !== 1'b1 || fwd_rs1_data !== 32'h2) begin failures++; $display("FAIL youngest got=%b/%h exp=1/00000002", fwd_rs1_hit, fwd_rs1_data); end
    drain();
    // ALU writer then load to same reg: young load not ready masks older result
    writer(5'd8, 0); tick();
    writer(5'd8, 1); tick();
    idle(); id_valid = 1; id_rs1 = 5'd8; id_rs1_used = 1; rf_rs1_data = 32'h99; #1;
    checks++; if (stall !== 1'b1 || fwd_rs1_hit !== 1'b0) begin failures++; $display("FAIL young_load_masks got=%b/%b exp=1/0", stall, fwd_rs1_hit); end
    // operand not used -> no stall
    id_rs1_used = 0; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL unused_no_stall got=%b exp=0", stall); end
    drain();
    // forwarding from WB
    writer(5'd3, 0); tick();
    idle(); tick(); tick();
    id_valid = 1; id_rs2 = 5'd3; id_rs2_used = 1; stage_data = {32'hCAFE, 32'h1, 32'h2}; #1;
    checks++; if (fwd_rs2_hit !== 1'b1 || fwd_rs2_data !== 32'hCAFE) begin failures++; $display("FAIL wb_fwd got=%b/%h exp=1/0000cafe", fwd_rs2_hit, fwd_rs2_data); end
    drain();
  endtask

  task automatic test_hold_flush();
    writer(5'd10, 0); tick();
    writer(5'd11, 0); id_rs1 = 5'd10; id_rs1_used = 1;
    hold = 1; flush = 1; stage_data = {32'h0, 32'h20A, 32'h10A};
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (fwd_rs1_hit !== 1'b1 || fwd_rs1_data !== 32'h10A) begin failures++; $display("FAIL hold_frozen c=%0d got=%b/%h exp=1/0000010a", c, fwd_rs1_hit, fwd_rs1_data); end
    end
    hold = 0; flush = 0;
    tick();
    checks++; if (fwd_rs1_hit !== 1'b1 || fwd_rs1_data !== 32'h20A) begin failures++; $display("FAIL flush_shift got=%b/%h exp=1/0000020a", fwd_rs1_hit, fwd_rs1_data); end
    id_rs1 = 5'd11; rf_rs1_data = 32'h44; #1;
    checks++; if (fwd_rs1_hit !== 1'b0 || fwd_rs1_data !== 32'h44) begin failures++; $display("FAIL flush_bubble got=%b/%h exp=0/00000044", fwd_rs1_hit, fwd_rs1_data); end
    tick();
    checks++; if (fwd_rs1_hit !== 1'b1 || fwd_rs1_data !== 32'h10A) begin failures++; $display("FAIL flush_pend_clear got=%b/%h exp=1/0000010a", fwd_rs1_hit, fwd_rs1_data); end
    drain();
    // flush during a load-use stall: bubble, never issued
    writer(5'd12, 1); tick();
    writer(5'd13, 0); id_rs1 = 5'd12; id_rs1_used = 1; flush = 1; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL flush_stall_out got=%b exp=1", stall); end
    tick(); flush = 0;
    id_rs1 = 5'd13; #1;
    checks++; if (fwd_rs1_hit !== 1'b0) begin failures++; $display("FAIL flush_over_stall got=%b exp=0", fwd_rs1_hit); end
    drain();
  endtask

  task automatic test_async_reset();
    writer(5'd14, 0); tick();
    writer(5'd13, 1); tick();
    idle(); id_valid = 1; id_rs1 = 5'd13; id_rs1_used = 1; id_rs2 = 5'd14; id_rs2_used = 1;
    stage_data = {32'h0, 32'hE14, 32'hD13}; #1;
    checks++; if (stall !== 1'b1 || fwd_rs2_hit !== 1'b1) begin failures++; $display("FAIL pre_reset got=%b/%b exp=1/1", stall, fwd_rs2_hit); end
    #1 RST = 0; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL async_rst_stall got=%b exp=0", stall); end
    checks++; if (fwd_rs2_hit !== 1'b0) begin failures++; $display("FAIL async_rst_entries got=%b exp=0", fwd_rs2_hit); end
    @(negedge CLK); RST = 1; #1;
    checks++; if (stall !== 1'b0 || fwd_rs1_hit !== 1'b0) begin failures++; $display("FAIL after_rst got=%b/%b exp=0/0", stall, fwd_rs1_hit); end
    idle();
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_x0();
    test_youngest();
    test_hold_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
